// File: rtl/reg_writeback_unit_pkg.sv
// reg_writeback_unit_pkg: shared widths, idle write select and load-queue entry type.
package reg_writeback_unit_pkg;
    localparam int REG_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_W:0] WB_IDLE_SEL = 6'b100000;

    typedef struct packed {
        logic [REG_W-1:0]  dest;
        logic [DATA_W-1:0] data;
    } ld_entry_t;

    // r0 is hardwired, so any write to it collapses to the idle select
    function automatic logic [REG_W:0] gpr_sel(input logic [REG_W-1:0] dest);
        return (dest == '0) ? WB_IDLE_SEL : {1'b0, dest};
    endfunction
endpackage

// File: rtl/reg_writeback_unit_if.sv
// reg_writeback_unit_if: ALU/load/branch request inputs and register-file/PC writeback outputs.
interface reg_writeback_unit_if;
    import reg_writeback_unit_pkg::*;
    logic              alu_valid;
    logic [REG_W-1:0]  alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              ld_issue;
    logic [REG_W-1:0]  ld_issue_dest;
    logic              ld_valid;
    logic [REG_W-1:0]  ld_dest;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;
    logic              branch_valid;
    logic [DATA_W-1:0] branch_target;
    logic [REG_W-1:0]  read_a;
    logic [REG_W-1:0]  read_b;
    logic [REG_W:0]    write_sel;
    logic [DATA_W-1:0] data_in;
    logic              pc_write;
    logic [DATA_W-1:0] program_counter;
    logic              stall;

    modport master (
        output alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
               ld_valid, ld_dest, ld_data, branch_valid, branch_target, read_a, read_b,
        input  ld_ready, write_sel, data_in, pc_write, program_counter, stall
    );
    modport slave (
        input  alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
               ld_valid, ld_dest, ld_data, branch_valid, branch_target, read_a, read_b,
        output ld_ready, write_sel, data_in, pc_write, program_counter, stall
    );
endinterface

// File: rtl/reg_writeback_unit_load_queue.sv
// wb_load_queue: synchronous FIFO of returned loads; caller never pushes when full or pops when empty.
module wb_load_queue
    import reg_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  ld_entry_t push_entry,
    input  logic      pop,
    output ld_entry_t head,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);
    ld_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;

    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= push_entry;
endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: GPR/PC writeback with a load-return queue and load-pending scoreboard.
// Define WB_LOAD_BYPASS_EN to drop stall in the cycle a load is presented on write_sel.
module reg_writeback_unit
    import reg_writeback_unit_pkg::*;
#(
    parameter int LQ_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    reg_writeback_unit_if.slave wb
);
    logic ld_fire, take_ld, q_push, q_pop, q_full, q_empty, load_commit;
    logic [REG_W-1:0] commit_dest;
    logic [31:0] pending, set_vec, clr_vec, visible;
    logic [REG_W:0] sel_nxt;
    ld_entry_t in_entry, q_head, ld_head;

    assign ld_fire = wb.ld_valid & wb.ld_ready;
    assign wb.ld_ready = ~q_full;
    assign in_entry = '{dest: wb.ld_dest, data: wb.ld_data};
    // an empty queue forwards the incoming load straight to the write port
    assign ld_head = q_empty ? in_entry : q_head;
    assign take_ld = ~wb.alu_valid & (~q_empty | ld_fire);
    assign q_pop = take_ld & ~q_empty;
    assign q_push = ld_fire & ~(q_empty & ~wb.alu_valid);
    assign sel_nxt = wb.alu_valid ? gpr_sel(wb.alu_dest) : take_ld ? gpr_sel(ld_head.dest) : WB_IDLE_SEL;
    assign set_vec = wb.ld_issue ? (32'd1 << wb.ld_issue_dest) & ~32'd1 : '0;
    assign clr_vec = load_commit ? 32'd1 << commit_dest : '0;
`ifdef WB_LOAD_BYPASS_EN
    assign visible = pending & ~clr_vec;
`else
    assign visible = pending;
`endif
    assign wb.stall = visible[wb.read_a] | visible[wb.read_b];

    wb_load_queue #(.DEPTH(LQ_DEPTH)) u_queue (
        .clk(clk),
        .reset(reset),
        .push(q_push),
        .push_entry(in_entry),
        .pop(q_pop),
        .head(q_head),
        .full(q_full),
        .empty(q_empty)
    );

    // set_vec is applied after the clear so a re-issue in the commit cycle keeps the bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            load_commit <= 1'b0;
            commit_dest <= '0;
            wb.write_sel <= WB_IDLE_SEL;
            wb.data_in <= '0;
            wb.pc_write <= 1'b0;
            wb.program_counter <= '0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            load_commit <= take_ld;
            commit_dest <= ld_head.dest;
            wb.write_sel <= sel_nxt;
            wb.data_in <= sel_nxt[REG_W] ? '0 : wb.alu_valid ? wb.alu_data : ld_head.data;
            wb.pc_write <= wb.branch_valid;
            if (wb.branch_valid) wb.program_counter <= wb.branch_target;
        end
    end
endmodule

// File: tb/tb_reg_writeback_unit.sv
// tb_reg_writeback_unit: directed stimulus with a scoreboard of expected register-file writes.
module tb_reg_writeback_unit;
    import reg_writeback_unit_pkg::*;

    typedef struct packed {
        logic [5:0]  sel;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    wr_t exp_q[$];

    reg_writeback_unit_if wb();
    reg_writeback_unit #(.LQ_DEPTH(4)) dut (.clk(clk), .reset(reset), .wb(wb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (wb.write_sel !== WB_IDLE_SEL) begin
            if (exp_q.size() == 0) chk("unexpected_write", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
            else begin
                e = exp_q.pop_front();
                chk("wb_sel", 32'(wb.write_sel), 32'(e.sel));
                chk("wb_data", wb.data_in, e.data);
            end
        end else chk("idle_data", wb.data_in, 32'd0);
    endtask

    initial begin
        wb.alu_valid = 0; wb.alu_dest = 0; wb.alu_data = 0;
        wb.ld_issue = 0; wb.ld_issue_dest = 0;
        wb.ld_valid = 0; wb.ld_dest = 0; wb.ld_data = 0;
        wb.branch_valid = 0; wb.branch_target = 0;
        wb.read_a = 0; wb.read_b = 0;
        tick();
        tick();
        chk("rst_sel", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        chk("rst_data", wb.data_in, 32'd0);
        chk("rst_pc_write", 32'(wb.pc_write), 32'd0);
        chk("rst_pc", wb.program_counter, 32'd0);
        chk("rst_stall", 32'(wb.stall), 32'd0);
        chk("rst_ld_ready", 32'(wb.ld_ready), 32'd1);
        reset = 1'b1;
        tick();
        // ALU write, then idle
        wb.alu_valid = 1; wb.alu_dest = 5; wb.alu_data = 32'hDEADBEEF;
        exp_q.push_back('{6'b000101, 32'hDEADBEEF});
        tick();
        wb.alu_valid = 0;
        chk("alu_latency", 32'(exp_q.size()), 32'd0);
        tick();
        chk("alu_then_idle", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        // pending load to r7 and its commit
        wb.ld_issue = 1; wb.ld_issue_dest = 7; wb.read_a = 7;
        tick();
        wb.ld_issue = 0;
        #1 chk("stall_read_a", 32'(wb.stall), 32'd1);
        wb.read_a = 0; wb.read_b = 7;
        #1 chk("stall_read_b", 32'(wb.stall), 32'd1);
        wb.ld_valid = 1; wb.ld_dest = 7; wb.ld_data = 32'h1234;
        exp_q.push_back('{6'b000111, 32'h1234});
        tick();
        wb.ld_valid = 0;
        chk("load_latency", 32'(exp_q.size()), 32'd0);
`ifdef WB_LOAD_BYPASS_EN
        #1 chk("stall_commit_cycle", 32'(wb.stall), 32'd0);
`else
        #1 chk("stall_commit_cycle", 32'(wb.stall), 32'd1);
`endif
        tick();
        chk("stall_after_commit", 32'(wb.stall), 32'd0);
        wb.read_b = 0;
        // fill the queue while the ALU (to r0) owns the write port
        wb.alu_valid = 1; wb.alu_dest = 0; wb.alu_data = 32'hFFFF;
        for (int i = 0; i < 4; i++) begin
            wb.ld_valid = 1; wb.ld_dest = 5'(10 + i); wb.ld_data = 32'hA000 + i;
            #1 chk("ld_ready_fill", 32'(wb.ld_ready), 32'd1);
            exp_q.push_back('{{1'b0, 5'(10 + i)}, 32'hA000 + i});
            tick();
            chk("alu_r0_drop", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        end
        wb.ld_dest = 20; wb.ld_data = 32'hBAD;
        #1 chk("ld_ready_full", 32'(wb.ld_ready), 32'd0);
        tick();
        chk("no_pop_under_alu", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        wb.ld_valid = 0; wb.alu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("fifo_consecutive", 32'(wb.write_sel[5]), 32'd0);
        end
        tick();
        chk("fifo_drained", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        chk("fifo_sb_empty", 32'(exp_q.size()), 32'd0);
        // load to r0 is consumed without a write
        wb.alu_valid = 1; wb.alu_dest = 0;
        wb.ld_valid = 1; wb.ld_dest = 0; wb.ld_data = 32'h55;
        tick();
        wb.ld_dest = 9; wb.ld_data = 32'h99;
        exp_q.push_back('{6'b001001, 32'h99});
        tick();
        wb.ld_valid = 0; wb.alu_valid = 0;
        tick();
        chk("r0_load_drop", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        tick();
        chk("r0_entry_consumed", 32'(exp_q.size()), 32'd0);
        // branch alongside an ALU write
        wb.branch_valid = 1; wb.branch_target = 32'h400;
        wb.alu_valid = 1; wb.alu_dest = 3; wb.alu_data = 32'h33;
        exp_q.push_back('{6'b000011, 32'h33});
        tick();
        wb.branch_valid = 0; wb.alu_valid = 0;
        chk("branch_pc_write", 32'(wb.pc_write), 32'd1);
        chk("branch_pc", wb.program_counter, 32'h400);
        chk("branch_gpr_too", 32'(exp_q.size()), 32'd0);
        tick();
        chk("pc_write_pulse", 32'(wb.pc_write), 32'd0);
        chk("pc_hold", wb.program_counter, 32'h400);
        // reset with queued loads and pending bits
        wb.alu_valid = 1; wb.alu_dest = 0;
        wb.ld_issue = 1; wb.ld_issue_dest = 12;
        wb.ld_valid = 1; wb.ld_dest = 12; wb.ld_data = 32'hC;
        tick();
        wb.alu_dest = 4; wb.alu_data = 32'h44;
        exp_q.push_back('{6'b000100, 32'h44});
        wb.branch_valid = 1; wb.branch_target = 32'h800;
        wb.ld_issue_dest = 13; wb.ld_dest = 13; wb.ld_data = 32'hD;
        tick();
        wb.alu_dest = 0; wb.branch_valid = 0; wb.ld_issue = 0; wb.ld_valid = 0;
        wb.read_a = 12; wb.read_b = 13;
        #1 chk("pre_rst_stall", 32'(wb.stall), 32'd1);
        chk("pre_rst_pc_write", 32'(wb.pc_write), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_sel", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        chk("mid_rst_data", wb.data_in, 32'd0);
        chk("mid_rst_pc_write", 32'(wb.pc_write), 32'd0);
        chk("mid_rst_pc", wb.program_counter, 32'd0);
        chk("mid_rst_stall", 32'(wb.stall), 32'd0);
        chk("mid_rst_ld_ready", 32'(wb.ld_ready), 32'd1);
        tick();
        wb.alu_valid = 0;
        reset = 1'b1;
        tick();
        chk("post_rst_idle", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        chk("post_rst_stall", 32'(wb.stall), 32'd0);
        tick();
        chk("post_rst_discarded", 32'(wb.write_sel), 32'(WB_IDLE_SEL));
        chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_writeback_unit.md
REG_WRITEBACK_UNIT -- requirements
Module: reg_writeback_unit

Interface
REQ-001 Parameter: LQ_DEPTH, default 4, load-return queue depth (power of two, >=2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 alu_valid / alu_dest / alu_data  input  1/5/32  ALU result to write back.
REQ-005 ld_issue / ld_issue_dest  input  1/5  load issued to memory; marks destination pending.
REQ-006 ld_valid / ld_dest / ld_data  input  1/5/32  load data return, offered to queue.
REQ-007 ld_ready  output  1  queue can accept; transfer occurs when ld_valid & ld_ready.
REQ-008 branch_valid / branch_target  input  1/32  PC redirect request.
REQ-009 read_a / read_b  input  5/5  decode-stage source registers, for hazard check.
REQ-010 write_sel  output  6  register-file write select; bit5=1 means no GPR write.
REQ-011 data_in  output  32  register-file write data.
REQ-012 pc_write / program_counter  output  1/32  PC register write strobe and value.
REQ-013 stall  output  1  decode must hold; a source has an outstanding load.

Function
REQ-014 write_sel, data_in, pc_write, program_counter are registered; one-cycle latency from accepted request to presentation.
REQ-015 Idle write_sel = 6'b100000, data_in = 0.
REQ-016 Per cycle at most one GPR write; ALU result has priority over queue head.
REQ-017 alu_valid in cycle N -> write_sel={1'b0,alu_dest}, data_in=alu_data in cycle N+1.
REQ-018 Queue head pops only in cycles with alu_valid=0; presented next cycle.
REQ-019 Writes to register 0 (ALU or load) are dropped: write_sel stays idle; a load pop to r0 still consumes the entry.
REQ-020 Queue FIFO order; ld_ready = not full; ld_ready evaluated from registered count, not from same-cycle pop.
REQ-021 Scoreboard: 32-bit pending vector; ld_issue sets bit ld_issue_dest (r0 ignored); load commit clears bit ld_dest.
REQ-022 Simultaneous set and clear of same bit: set wins.
REQ-023 stall = pending[read_a] | pending[read_b], r0 never pending.
REQ-024 branch_valid in cycle N -> pc_write=1, program_counter=branch_target in cycle N+1; program_counter holds value otherwise; pc_write is a one-cycle pulse.
REQ-025 branch and GPR writeback are independent and may occur in the same cycle.
REQ-026 alu_valid with pending alu_dest is a protocol violation; behaviour: ALU write proceeds, pending bit unchanged.

Reset
REQ-027 On reset low: queue empty, pending=0, write_sel=6'b100000, data_in=0, pc_write=0, program_counter=0, stall=0, ld_ready=1.
REQ-028 Reset mid-operation discards queued loads and pending bits immediately; no write presented in first cycle after release.

Configuration
REQ-029 Macro WB_LOAD_BYPASS_EN.
REQ-030 Defined: stall excludes a register whose load is being presented on write_sel this cycle (register file bypasses data_in); stall drops in commit cycle.
REQ-031 Undefined: pending bit clears on edge ending the commit cycle; stall drops one cycle later.

Structure
REQ-032 Shared package: WB_IDLE_SEL constant (6'b100000), REG_W=5, DATA_W=32, load-entry struct {dest, data}.
REQ-033 One sub-module: wb_load_queue (synchronous FIFO, push/pop/full/empty/count).

Verification
REQ-034 alu_valid, dest=5, data=0xDEADBEEF -> next cycle write_sel=6'b000101, data_in=0xDEADBEEF, then idle.
REQ-035 ld_issue dest=7; read_a=7 -> stall=1; ld_valid dest=7 data=0x1234 -> write_sel=6'b000111 next cycle; stall drops same cycle (macro on) or one cycle later (off).
REQ-036 Push 4 loads with alu_valid held high -> ld_ready=0 after 4th, no pops; release alu_valid -> 4 writes in FIFO order on consecutive cycles.
REQ-037 alu_valid dest=0 and load return dest=0 -> write_sel remains 6'b100000; queue entry consumed.
REQ-038 branch_valid target=0x00000400 with alu write same cycle -> next cycle pc_write=1, program_counter=0x400, GPR write also presented; pc_write=0 following cycle.
REQ-039 Assert reset with 2 queued loads and pending bits set -> all outputs at reset values, stall=0, ld_ready=1 immediately.
